// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, parity selectors and the parity helper.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic EVEN_PARITY    = 1'b0;
  localparam logic ODD_PARITY     = 1'b1;
  localparam int   MAX_DATA_WIDTH = 9;

  // Narrower words are zero-extended by the caller, which leaves the XOR reduction unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                       input logic                      par_typ);
    return (par_typ == ODD_PARITY) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock word FIFO with show-ahead read data and an occupancy counter.
// Pushes when full and pops when empty are ignored.
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_EMPTY = {CNT_W{1'b0}};

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_en_s, rd_en_s;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == CNT_EMPTY);
  assign wr_en_s = push & ~full;
  assign rd_en_s = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= CNT_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the counter alone defines which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: word FIFO feeding a frame FSM with per-frame latched
// parity, stop-bit and bit-time configuration. TX_OUT and BUSY are registered from the FSM state.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   DATA_VALID,
  output logic                   READY,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   STOP2,
  input  logic [PRESC_WIDTH-1:0] PRESCALE,
  output logic                   TX_OUT,
  output logic                   BUSY
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0]       IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]       IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
  localparam logic [PRESC_WIDTH-1:0] PRESC_ZERO = {PRESC_WIDTH{1'b0}};
  localparam logic [PRESC_WIDTH-1:0] PRESC_ONE  = PRESC_WIDTH'(1);

  uart_state_e             state_q;
  logic [PRESC_WIDTH-1:0]  cnt_q, presc_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    stop_idx_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_bit_q, par_en_q, stop2_q;
  logic                    tx_q, busy_q, rst_hold_q;

  logic                    push_s, pop_s, full_s, empty_s;
  logic                    bit_end_s, last_stop_s, line_s;
  logic [DATA_WIDTH-1:0]   rdata_s;
  logic [MAX_DATA_WIDTH-1:0] rdata_ext_s;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (P_DATA),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // READY stays low through the cycle following a reset edge, then tracks FIFO space.
  assign READY       = ~full_s & ~rst_hold_q;
  assign push_s      = DATA_VALID & READY;
  assign rdata_ext_s = MAX_DATA_WIDTH'(rdata_s);
  assign bit_end_s   = (cnt_q == (presc_q - PRESC_ONE));
  assign last_stop_s = ~stop2_q | stop_idx_q;
  assign pop_s       = ~empty_s & ((state_q == IDLE) |
                                   ((state_q == STOP) & bit_end_s & last_stop_s));
  assign TX_OUT      = tx_q;
  assign BUSY        = busy_q;

  always_comb begin
    line_s = 1'b1;
    case (state_q)
      START:   line_s = 1'b0;
      DATA:    line_s = shift_q[0];
      PARITY:  line_s = par_bit_q;
      default: line_s = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    rst_hold_q <= RST;
  end

  // Frame FSM; a pop always starts a new frame, from IDLE or from the last stop cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= PRESC_ZERO;
      presc_q    <= PRESC_ONE;
      idx_q      <= IDX_ZERO;
      stop_idx_q <= 1'b0;
      shift_q    <= {DATA_WIDTH{1'b0}};
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_q   <= line_s;
      busy_q <= (state_q != IDLE);
      if (pop_s) begin
        state_q    <= START;
        cnt_q      <= PRESC_ZERO;
        idx_q      <= IDX_ZERO;
        stop_idx_q <= 1'b0;
        shift_q    <= rdata_s;
        par_bit_q  <= calc_parity(rdata_ext_s, PAR_TYP);
        par_en_q   <= PAR_EN;
        stop2_q    <= STOP2;
        presc_q    <= (PRESCALE == PRESC_ZERO) ? PRESC_ONE : PRESCALE;
      end else if (state_q != IDLE) begin
        cnt_q <= bit_end_s ? PRESC_ZERO : (cnt_q + PRESC_ONE);
        if (bit_end_s) begin
          case (state_q)
            START: begin
              state_q <= DATA;
              idx_q   <= IDX_ZERO;
            end
            DATA: begin
              shift_q <= shift_q >> 1;
              if (idx_q == IDX_LAST) begin
                state_q <= par_en_q ? PARITY : STOP;
              end else begin
                idx_q <= idx_q + IDX_ONE;
              end
            end
            PARITY: state_q <= STOP;
            STOP: begin
              if (last_stop_s) begin
                state_q <= IDLE;
              end else begin
                stop_idx_q <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

- Parametrised UART transmitter with an internal word FIFO. Successor to the fixed 8-bit, even-parity, single-stop-bit frame generator used on the system link.
- Accepts data words through a valid/ready handshake and serialises them LSB-first on TX_OUT.
- Frame format is runtime-configurable: optional parity (even/odd), 1 or 2 stop bits, and a per-bit duration of PRESCALE clock cycles.
- Sits in the UART clock domain, between the data-sync/async-FIFO output and the TX pin.

## Interface
- DATA_WIDTH, 8: data bits per frame (5..9).
- FIFO_DEPTH, 4: buffered words (power of two, ≥2).
- PRESC_WIDTH, 6: width of PRESCALE.
- CLK  in  1: UART clock; all logic on the rising edge.
- RST  in  1: synchronous reset, active-high.
- P_DATA  in  DATA_WIDTH: word to transmit.
- DATA_VALID  in  1: P_DATA is valid; the word is pushed when DATA_VALID & READY at a rising edge.
- READY  out  1: FIFO not full.
- PAR_EN  in  1: parity bit enabled.
- PAR_TYP  in  1: 0 = even, 1 = odd.
- STOP2  in  1: two stop bits when 1.
- PRESCALE  in  PRESC_WIDTH: CLK cycles per bit; 0 is treated as 1.
- TX_OUT  out  1: serial line, idle high, registered.
- BUSY  out  1: a frame is in progress (START through the last STOP cycle).

## Operation
**Reset.** While RST is high:
- TX_OUT=1, BUSY=0, READY=0, FIFO flushed, FSM=IDLE.
- READY=1 from the first edge after RST falls.

**FSM states and transitions.**
- IDLE → START when the FIFO is non-empty. Pop one word into the shift register. Latch PAR_EN, PAR_TYP, STOP2 and PRESCALE (clamped to ≥1) into frame-config registers.
- START → DATA after one bit time.
- DATA → PARITY (if latched PAR_EN) or STOP after DATA_WIDTH bit times.
- PARITY → STOP after one bit time.
- STOP → START when the FIFO is non-empty at the last cycle of the last stop bit, with a pop and relatch as above. Otherwise STOP → IDLE.
- Bit count in STOP: 1, or 2 when latched STOP2 is set.

**Line values.** START=0, DATA=shift[0] (LSB first), STOP=1.

**Parity.**
- Even: parity bit = ^data, so the total number of ones is even.
- Odd: parity bit = ~^data.
- Computed from the popped word at frame start.

**Counters.**
- Bit-time counter runs 0..PRESCALE-1 and wraps.
- Data-bit index runs 0..DATA_WIDTH-1.
- Stop-bit index runs 0..1.

**Configuration changes.** Changes to PAR_EN, PAR_TYP, STOP2 or PRESCALE mid-frame have no effect until the next frame starts.

**FIFO.**
- Occupancy counter 0..FIFO_DEPTH; READY = (count != FIFO_DEPTH).
- Push and pop in the same cycle: count unchanged, data order preserved.
- When full, a push is refused even if a pop happens in the same cycle. READY rises the edge after the pop.
- Pop on empty never occurs, because the FSM gates the pop on non-empty.

**Reset mid-frame.** TX_OUT returns to 1 on the reset edge. The partial frame is abandoned and buffered words are discarded.

## Timing
- Push latency: word accepted at edge N with the FIFO empty and the FSM in IDLE → TX_OUT=0 after edge N+2.
- Frame length: (1 + DATA_WIDTH + PAR_EN + 1 + STOP2) × PRESCALE cycles.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- BUSY asserts in the same cycle TX_OUT first goes 0. It deasserts in the same cycle TX_OUT is held idle after the final stop bit.
- Throughput: one word per frame time. A burst of FIFO_DEPTH words plus one in flight is absorbed without stalling the producer.

## Structure
**Package uart_pkg:**
- FSM state enum: IDLE, START, DATA, PARITY, STOP.
- EVEN_PARITY=1'b0, ODD_PARITY=1'b1.
- Shared with the RX side.

**Sub-module uart_sync_fifo:**
- Parameters DATA_WIDTH, FIFO_DEPTH.
- Ports: CLK, RST, push, pop, wdata, rdata, full, empty.
- Synchronous reset.
- Reusable by the receiver path.

**Top level.** FSM, bit-time counter, bit index, shift register, parity and the TX_OUT register live in uart_tx_buffered.

## Test plan
- **Single frame, even parity.** PRESCALE=4, PAR_EN=1, PAR_TYP=0, STOP2=0. Push 0xA5.
  - TX_OUT: 0, then 1,0,1,0,0,1,0,1, then parity 0, stop 1.
  - Each level held 4 cycles; frame is 44 cycles.
  - BUSY high for exactly 44 cycles.
- **Odd parity, two stop bits, no prescale.** PRESCALE=0 (treated as 1), PAR_TYP=1, STOP2=1. Push 0x03.
  - Parity bit = 1.
  - Two stop cycles.
  - Frame is 12 cycles.
- **Burst into full FIFO.** PRESCALE=2, PAR_EN=0. Push 5 words 0x11..0x55 on consecutive cycles.
  - READY drops after the 5th accept, since 1 word is in flight and 4 are buffered.
  - A 6th push is refused.
  - All 5 frames go out back-to-back with no idle cycles, in order.
- **Mid-frame configuration change.** Change PAR_EN 1→0 and PRESCALE 4→8 during a frame.
  - The current frame keeps parity and 4-cycle bits.
  - The next frame has no parity and 8-cycle bits.
- **Reset mid-frame.** Assert RST during the DATA state with 2 words buffered.
  - TX_OUT=1, BUSY=0, READY=0 on the reset edge.
  - After release: READY=1, and no frame starts until a new push.
- **Simultaneous push and pop.** Push exactly at the frame-start pop with count=2.
  - Count stays 2.
  - The word order of the subsequent frames is correct.
